// File: rtl/usb_fifo_pkg.sv
// Shared types and defaults for the USB receive FIFO.
package usb_fifo_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DROP = 2'd2
    } rx_state_e;

    localparam int unsigned FIFO_DEPTH_LOG2_DEF = 6;

endpackage

// File: rtl/fifo_ram.sv
// Byte storage for the receive FIFO: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_rx_fifo.sv
// Packet-aware receive FIFO: bytes stay tentative until end-of-packet, errored or
// overflowing packets are rolled back without touching committed data.
module usb_rx_fifo
    import usb_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_eop,
    input  logic                  in_err,
    input  logic                  rd,
    input  logic                  wr,
    output logic                  drdy,
    output logic [7:0]            d,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  pkt_drop,
    output logic                  overflow
);

    typedef logic [DEPTH_LOG2:0] ptr_t;

    localparam ptr_t DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};

    rx_state_e state, state_n;
    ptr_t      rptr, cptr, wptr;
    ptr_t      rptr_n, cptr_n, wptr_n;
    ptr_t      occ;
    logic      full;
    logic      we;
    logic      drop_n, ovf_n;
    logic [7:0] rdata;

    assign occ   = wptr - rptr;
    assign full  = (occ == DEPTH_P);
    assign drdy  = (cptr != rptr);
    assign level = cptr - rptr;
    assign d     = drdy ? rdata : '0;

    // Write-side FSM; wptr only ever runs ahead of cptr inside RECV, so rollback is wptr <= cptr.
    always_comb begin
        state_n = state;
        wptr_n  = wptr;
        cptr_n  = cptr;
        we      = 1'b0;
        drop_n  = 1'b0;
        ovf_n   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (in_valid && !in_err) begin
                    if (full) begin
                        ovf_n = 1'b1;
                        if (in_eop) begin
                            drop_n = 1'b1;
                        end else begin
                            state_n = RX_DROP;
                        end
                    end else begin
                        we     = 1'b1;
                        wptr_n = wptr + 1'b1;
                        if (in_eop) begin
                            cptr_n = wptr + 1'b1;
                        end else begin
                            state_n = RX_RECV;
                        end
                    end
                end
            end
            RX_RECV: begin
                if (in_err) begin
                    wptr_n  = cptr;
                    drop_n  = 1'b1;
                    state_n = RX_IDLE;
                end else if (in_valid && full) begin
                    ovf_n  = 1'b1;
                    wptr_n = cptr;
                    if (in_eop) begin
                        drop_n  = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        state_n = RX_DROP;
                    end
                end else begin
                    if (in_valid) begin
                        we     = 1'b1;
                        wptr_n = wptr + 1'b1;
                    end
                    if (in_eop) begin
                        cptr_n  = wptr_n;
                        state_n = RX_IDLE;
                    end
                end
            end
            RX_DROP: begin
                if (in_eop || in_err) begin
                    drop_n  = 1'b1;
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    // Flush takes priority over pop.
    always_comb begin
        rptr_n = rptr;
        if (wr) begin
            rptr_n = cptr;
        end else if (rd && drdy) begin
            rptr_n = rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            rptr     <= '0;
            cptr     <= '0;
            wptr     <= '0;
            pkt_drop <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            rptr     <= rptr_n;
            cptr     <= cptr_n;
            wptr     <= wptr_n;
            pkt_drop <= drop_n;
            overflow <= ovf_n;
        end
    end

    fifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr[DEPTH_LOG2-1:0]),
        .wdata (in_data),
        .raddr (rptr[DEPTH_LOG2-1:0]),
        .rdata (rdata)
    );

endmodule
